fpm_wb_tracker: RTL and testbench

Issue-side and write-back-side companion to the pipelined single-precision multiplier. The multiplier has a fixed latency and no valid or stall signals. This block carries a valid bit and destination-register tag alongside each multiply. It captures each result into a small FIFO as it emerges and presents it to the register-file write-back port over a valid/ready handshake. Credit-based issue throttling guarantees that no result is ever dropped, because the multiplier pipeline cannot be stalled.

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fpm_result_fifo.sv | 57 +++++
 rtl/fpm_wb_tracker.sv | 103 ++++++++++
 tb/tb_fpm_wb_tracker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants for the single-precision multiplier: latency, IEEE-754 field
// positions, write-back flag indices and the flag decode helper.
package fp_pkg;

    localparam int FPM_LATENCY = 25;

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MANT_HI  = 22;
    localparam int MANT_LO  = 0;

    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

    // Denormals deliberately carry no flag; zero ignores the sign bit.
    function automatic logic [2:0] fp_flags(input logic [31:0] f);
        logic [2:0] fl;
        logic       exp_max;
        exp_max           = (f[EXP_HI:EXP_LO] == 8'hFF);
        fl                = '0;
        fl[FLAG_NAN]      = exp_max && (f[MANT_HI:MANT_LO] != '0);
        fl[FLAG_INF]      = exp_max && (f[MANT_HI:MANT_LO] == '0);
        fl[FLAG_ZERO]     = (f[SIGN_BIT-1:0] == '0);
        return fl;
    endfunction

endpackage

// File: rtl/fpm_result_fifo.sv
// Small synchronous FIFO with a registered head. Pointers carry a phase bit so
// equal indices distinguish empty from full; a push into an empty FIFO shows next cycle.
module fpm_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr, wptr_n, rptr_n;
    logic             do_pop;

    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1))
            return {~p[AW], {AW{1'b0}}};
        return {p[AW], p[AW-1:0] + AW'(1)};
    endfunction

    assign do_pop = pop & head_valid;

    always_comb begin
        wptr_n = push   ? ptr_inc(wptr) : wptr;
        rptr_n = do_pop ? ptr_inc(rptr) : rptr;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= push_data;
    end

    // Head is preloaded from the slot the next read pointer selects, bypassing
    // the entry being written this edge when it lands in that same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            wptr       <= wptr_n;
            rptr       <= rptr_n;
            head_valid <= (wptr_n != rptr_n);
            head_data  <= (push && (wptr[AW-1:0] == rptr_n[AW-1:0])) ? push_data
                                                                     : mem[rptr_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/fpm_wb_tracker.sv
// Tags each multiply with {valid, rd} through a fixed-latency shadow pipe, captures
// results into a FIFO for write-back, and throttles issue with a credit counter.
module fpm_wb_tracker
    import fp_pkg::*;
#(
    parameter int LATENCY = FPM_LATENCY,
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic [TAG_W-1:0]           issue_rd,
    output logic                       issue_ready,
    input  logic [31:0]                mul_result,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [TAG_W-1:0]           wb_rd,
    output logic [31:0]                wb_data,
    output logic [2:0]                 wb_flags,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       busy
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] rd;
        logic [31:0]      data;
        logic [2:0]       flags;
    } wb_entry_t;

    logic [LATENCY-1:0]            vld_pipe;
    logic [LATENCY-1:0][TAG_W-1:0] rd_pipe;
    logic                          accept, pop;
    logic [CW-1:0]                 out_n;
    wb_entry_t                     cap_entry, head;

    assign issue_ready = !rst && (outstanding < CW'(DEPTH));
    assign accept      = issue_valid & issue_ready;
    assign pop         = wb_valid & wb_ready;

    // Only valid bits are reset; products already in flight emerge untagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            for (int i = 1; i < LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        rd_pipe[0] <= issue_rd;
        for (int i = 1; i < LATENCY; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end

    always_comb begin
        cap_entry.rd    = rd_pipe[LATENCY-1];
        cap_entry.data  = mul_result;
        cap_entry.flags = fp_flags(mul_result);
    end

    // Credit is returned on pop, not capture, so the FIFO can never overflow.
    always_comb begin
        out_n = outstanding;
        case ({accept, pop})
            2'b10:   out_n = outstanding + CW'(1);
            2'b01:   out_n = outstanding - CW'(1);
            default: out_n = outstanding;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            busy        <= 1'b0;
        end else begin
            outstanding <= out_n;
            busy        <= (out_n != '0);
        end
    end

    fpm_result_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(TAG_W + 35)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_pipe[LATENCY-1]),
        .push_data (cap_entry),
        .pop       (pop),
        .head_valid(wb_valid),
        .head_data (head)
    );

    assign wb_rd    = head.rd;
    assign wb_data  = head.data;
    assign wb_flags = head.flags;

endmodule

// File: tb/tb_fpm_wb_tracker.sv
// Scoreboard bench: a stand-in multiplier delays chosen products by LATENCY, a
// reference model tracks credits and expected retirements, a monitor checks outputs.
module tb_fpm_wb_tracker;

    localparam int L     = 25;
    localparam int TW    = 5;
    localparam int D     = 4;
    localparam int CW    = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_valid = 1'b0;
    logic [TW-1:0] issue_rd = '0;
    logic          issue_ready;
    logic [31:0]   mul_result = '0;
    logic          wb_valid;
    logic          wb_ready = 1'b1;
    logic [TW-1:0] wb_rd;
    logic [31:0]   wb_data;
    logic [2:0]    wb_flags;
    logic [CW-1:0] outstanding;
    logic          busy;

    logic [31:0]   issue_prod = '0;

    fpm_wb_tracker #(.LATENCY(L), .TAG_W(TW), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .mul_result (mul_result),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_flags   (wb_flags),
        .outstanding(outstanding),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cap;
        logic [TW-1:0] rd;
        logic [31:0]   data;
        logic [2:0]    flags;
    } exp_t;

    typedef struct {
        int unsigned due;
        logic [31:0] val;
    } mq_t;

    exp_t        sb_q[$];
    mq_t         mul_q[$];
    int unsigned cyc = 0;
    int          model_out = 0;
    int          n_acc = 0;
    bit          pop_pend = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] ref_flags(input logic [31:0] v);
        int unsigned e, m;
        e = (v >> 23) & 32'hFF;
        m = v & 32'h7FFFFF;
        return {e == 255 && m != 0, e == 255 && m == 0, (v & 32'h7FFFFFFF) == 0};
    endfunction

    // Reference model plus stand-in multiplier, advanced once per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                model_out = 0;
                sb_q.delete();
            end else begin
                bit acc;
                acc = issue_valid && (model_out < D);
                if (acc) begin
                    n_acc++;
                    mul_q.push_back('{due: cyc + L, val: issue_prod});
                    sb_q.push_back('{cap: cyc + L, rd: issue_rd, data: issue_prod,
                                     flags: ref_flags(issue_prod)});
                end
                model_out = model_out + int'(acc) - int'(pop_pend);
            end
            pop_pend = 0;
            #1;
            if (mul_q.size() > 0 && mul_q[0].due == cyc + 1)
                mul_result = mul_q.pop_front().val;
            else
                mul_result = $urandom;
        end
    end

    // Monitor: compares every cycle, pops the scoreboard on each handshake.
    initial begin
        forever begin
            bit exp_valid;
            @(negedge clk);
            exp_valid = (sb_q.size() > 0) && (sb_q[0].cap <= cyc);
            chk("issue_ready", 32'(issue_ready), 32'(!rst && model_out < D));
            chk("outstanding", 32'(outstanding), 32'(model_out));
            chk("busy", 32'(busy), 32'(model_out != 0));
            chk("wb_valid", 32'(wb_valid), 32'(exp_valid));
            if (wb_valid && wb_ready) begin
                pop_pend = 1;
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                    chk("wb_flags", 32'(wb_flags), 32'(e.flags));
                end else begin
                    chk("unexpected_retire", 32'(wb_rd), 32'hFFFF_FFFF);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [TW-1:0] rd, input logic [31:0] prod);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_prod  = prod;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < budget) begin
            step();
            k++;
        end
        chk(nm, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int start, guard;

        step(2);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_wb_rd", 32'(wb_rd), 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_wb_flags", 32'(wb_flags), 32'd0);
        chk("reset_outstanding", 32'(outstanding), 32'd0);
        step();

        // single op: 2.0 * 3.0
        issue(5'd3, 32'h40C0_0000);
        wait_drain("single_drain", L + 10);
        step(2);

        // back-pressure: fill all credits, 5th request must be ignored
        wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) issue(TW'(i), $urandom);
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        issue_prod  = $urandom;
        step(L + 4);
        @(negedge clk);
        chk("bp_outstanding", 32'(outstanding), 32'd4);
        chk("bp_issue_ready", 32'(issue_ready), 32'd0);
        step();
        issue_valid = 1'b0;
        wb_ready    = 1'b1;
        wait_drain("bp_drain", 20);
        step(2);

        // simultaneous issue and pop at outstanding 3
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(TW'(10 + i), $urandom);
        step(L + 2);
        issue_valid = 1'b1;
        issue_rd    = 5'd20;
        issue_prod  = $urandom;
        wb_ready    = 1'b1;
        step();
        issue_valid = 1'b0;
        wb_ready    = 1'b0;
        @(negedge clk);
        chk("simul_outstanding", 32'(outstanding), 32'd3);
        step();
        wb_ready = 1'b1;
        wait_drain("simul_drain", L + 10);
        step(2);

        // special-value flags
        issue(5'd7, 32'h7F80_0000);
        issue(5'd8, 32'h0000_0000);
        issue(5'd9, 32'h7FC0_0000);
        wait_drain("flags_drain", L + 10);
        step(2);

        // reset while two ops are in flight
        issue(5'd1, $urandom);
        issue(5'd2, $urandom);
        step(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_outstanding", 32'(outstanding), 32'd0);
        chk("midrst_ready", 32'(issue_ready), 32'd1);
        step(L + 5);

        // random streaming with random back-pressure
        start = n_acc;
        guard = 0;
        while (n_acc < start + 100 && guard < 4000) begin
            int sel;
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rd    = TW'($urandom);
            sel         = $urandom_range(0, 7);
            case (sel)
                0:       issue_prod = 32'h7F80_0000 | (32'($urandom_range(0, 1)) << 31);
                1:       issue_prod = 32'h7F80_0000 | 32'($urandom_range(1, 32'h7FFFFF));
                2:       issue_prod = 32'($urandom_range(0, 1)) << 31;
                default: issue_prod = $urandom;
            endcase
            wb_ready = ($urandom_range(0, 2) != 0);
            step();
            guard++;
        end
        chk("stream_accepts", 32'(n_acc - start), 32'd100);
        issue_valid = 1'b0;
        wb_ready    = 1'b1;
        wait_drain("stream_drain", L + 20);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
